// File: rtl/dbi_burst_encoder_if.sv
// Beat handshake bundle between the write-data source, the DBI encoder
// and the pad-side output register.
interface dbi_burst_encoder_if #(
    parameter int DATA_W = 8
);
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_dbi;
    logic              m_last;
    logic              m_ready;

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_dbi, m_last
    );

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_dbi, m_last
    );
endinterface

// File: rtl/dbi_burst_encoder.sv
// Burst-framed DBI encoder: AC (min transitions) or DC (min zeros) rule,
// bus parks high between bursts, saturating inverted-beat counter.
module dbi_burst_encoder #(
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 8,
    parameter int CNT_W     = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mode,
    input  logic                stat_clr,
    output logic [CNT_W-1:0]    inv_cnt,
    dbi_burst_encoder_if.slave  bus
);
    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int PW = $clog2(DATA_W + 2);
    localparam logic [BW-1:0] LAST = BW'(BURST_LEN - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BURST = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_PARK  = 2'd3;

    logic [1:0]        r_state;
    logic [BW-1:0]     r_beat_cnt;
    logic              r_mode;
    logic              r_valid;
    logic              r_last;
    logic              r_dbi;
    logic [DATA_W-1:0] r_data;
    logic [CNT_W-1:0]  r_inv_cnt;

    logic              w_s_ready;
    logic              w_accept;
    logic              w_xfer;
    logic              w_mode;
    logic              w_inv;
    logic [PW-1:0]     w_diff;
    logic [PW-1:0]     w_t_true;
    logic [PW-1:0]     w_t_inv;
    logic [PW-1:0]     w_zeros;

    function automatic logic [PW-1:0] popcnt(input logic [DATA_W-1:0] v);
        logic [PW-1:0] c;
        c = '0;
        for (int i = 0; i < DATA_W; i++) begin
            c = c + PW'(v[i]);
        end
        return c;
    endfunction

    always_comb begin
        w_s_ready = ((r_state == ST_IDLE) || (r_state == ST_BURST))
                    && (!r_valid || bus.m_ready);
        w_accept  = bus.s_valid && w_s_ready;
        w_xfer    = r_valid && bus.m_ready;
        w_mode    = (r_state == ST_IDLE) ? mode : r_mode;
        // Transition cost counts the DBI wire as a ninth lane
        w_diff    = popcnt(bus.s_data ^ r_data);
        w_t_true  = w_diff + PW'(r_dbi);
        w_t_inv   = PW'(DATA_W) - w_diff + PW'(!r_dbi);
        w_zeros   = PW'(DATA_W) - popcnt(bus.s_data);
        w_inv     = w_mode ? (w_t_inv < w_t_true)
                           : (w_zeros > PW'(DATA_W / 2));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_beat_cnt <= '0;
            r_mode     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_mode <= mode;
                        if (BURST_LEN == 1) begin
                            r_state <= ST_DRAIN;
                        end else begin
                            r_beat_cnt <= BW'(1);
                            r_state    <= ST_BURST;
                        end
                    end
                end
                ST_BURST: begin
                    if (w_accept) begin
                        if (r_beat_cnt == LAST) begin
                            r_beat_cnt <= '0;
                            r_state    <= ST_DRAIN;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + BW'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_xfer && r_last) begin
                        r_state <= ST_PARK;
                    end
                end
                ST_PARK: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Output register doubles as the AC reference for the next beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= '1;
            r_dbi   <= 1'b0;
        end else if (r_state == ST_PARK) begin
            r_valid <= 1'b0;
            r_data  <= '1;
            r_dbi   <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_last  <= (r_beat_cnt == LAST);
            r_data  <= w_inv ? ~bus.s_data : bus.s_data;
            r_dbi   <= w_inv;
        end else if (w_xfer) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inv_cnt <= '0;
        end else if (stat_clr) begin
            r_inv_cnt <= '0;
        end else if (w_accept && w_inv && (r_inv_cnt != '1)) begin
            r_inv_cnt <= r_inv_cnt + CNT_W'(1);
        end
    end

    assign bus.s_ready = w_s_ready;
    assign bus.m_valid = r_valid;
    assign bus.m_data  = r_data;
    assign bus.m_dbi   = r_dbi;
    assign bus.m_last  = r_last;
    assign inv_cnt     = r_inv_cnt;

endmodule

// File: tb/tb_dbi_burst_encoder.sv
// Scoreboard bench for dbi_burst_encoder: directed cases plus random
// traffic against a rule-level reference model.
module tb_dbi_burst_encoder;
    localparam int DW = 8;
    localparam int BL = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mode = 1'b0;
    logic        stat_clr = 1'b0;
    logic [15:0] inv_cnt;
    logic [1:0]  inv_cnt2;

    dbi_burst_encoder_if #(.DATA_W(DW)) bif ();
    dbi_burst_encoder_if #(.DATA_W(DW)) bif2 ();

    assign bif2.s_valid = bif.s_valid;
    assign bif2.s_data  = bif.s_data;
    assign bif2.m_ready = bif.m_ready;

    dbi_burst_encoder #(.DATA_W(DW), .BURST_LEN(BL), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .stat_clr(stat_clr),
        .inv_cnt(inv_cnt), .bus(bif)
    );

    dbi_burst_encoder #(.DATA_W(DW), .BURST_LEN(BL), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .stat_clr(stat_clr),
        .inv_cnt(inv_cnt2), .bus(bif2)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [7:0] d;
        logic       dbi;
        logic       last;
    } beat_t;

    beat_t      q[$];
    logic [7:0] ref_d;
    logic       ref_dbi;
    int         beat_idx;
    logic       burst_mode;
    int         cnt_model;
    int         cnt2_model;
    logic       prev_stall;
    beat_t      held;

    function automatic logic enc_inv(input logic [7:0] d, input logic m,
                                     input logic [7:0] rd, input logic rdbi);
        int tt;
        int ti;
        if (m) begin
            tt = $countones(d ^ rd) + (rdbi ? 1 : 0);
            ti = $countones(~d ^ rd) + (rdbi ? 0 : 1);
            return ti < tt;
        end
        return $countones(~d) > DW / 2;
    endfunction

    // Monitor + model: compare first, then apply this cycle's handshakes
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            ref_d      = 8'hFF;
            ref_dbi    = 1'b0;
            beat_idx   = 0;
            burst_mode = 1'b0;
            cnt_model  = 0;
            cnt2_model = 0;
            prev_stall = 1'b0;
        end else begin
            logic  acc;
            logic  inv;
            beat_t b;
            beat_t e;
            check("inv_cnt", 32'(inv_cnt), 32'(cnt_model));
            check("inv_cnt_w2", 32'(inv_cnt2), 32'(cnt2_model));
            if (prev_stall) begin
                check("hold_valid", 32'(bif.m_valid), 32'd1);
                check("hold_data", 32'(bif.m_data), 32'(held.d));
                check("hold_dbi", 32'(bif.m_dbi), 32'(held.dbi));
                check("hold_last", 32'(bif.m_last), 32'(held.last));
            end
            if (bif.m_valid && bif.m_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_beat", 32'(bif.m_data), 32'h100);
                end else begin
                    e = q.pop_front();
                    check("beat_data", 32'(bif.m_data), 32'(e.d));
                    check("beat_dbi", 32'(bif.m_dbi), 32'(e.dbi));
                    check("beat_last", 32'(bif.m_last), 32'(e.last));
                end
            end
            prev_stall = bif.m_valid && !bif.m_ready;
            held = '{d: bif.m_data, dbi: bif.m_dbi, last: bif.m_last};
            acc = bif.s_valid && bif.s_ready;
            inv = 1'b0;
            if (acc) begin
                if (beat_idx == 0) burst_mode = mode;
                inv = enc_inv(bif.s_data, burst_mode, ref_d, ref_dbi);
                b.d    = inv ? ~bif.s_data : bif.s_data;
                b.dbi  = inv;
                b.last = (beat_idx == BL - 1);
                q.push_back(b);
                ref_d   = b.d;
                ref_dbi = b.dbi;
                beat_idx++;
                if (beat_idx == BL) begin
                    beat_idx = 0;
                    ref_d    = 8'hFF;
                    ref_dbi  = 1'b0;
                end
            end
            if (stat_clr) begin
                cnt_model  = 0;
                cnt2_model = 0;
            end else if (acc && inv) begin
                if (cnt_model < 65535) cnt_model++;
                if (cnt2_model < 3) cnt2_model++;
            end
        end
    end

    task automatic send(input logic [7:0] d);
        int t;
        bif.s_valid = 1'b1;
        bif.s_data  = d;
        t = 0;
        @(negedge clk);
        while (!bif.s_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #2;
        bif.s_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_m_valid"}, 32'(bif.m_valid), 32'd0);
        check({tag, "_m_last"}, 32'(bif.m_last), 32'd0);
        check({tag, "_m_data"}, 32'(bif.m_data), 32'hFF);
        check({tag, "_m_dbi"}, 32'(bif.m_dbi), 32'd0);
        check({tag, "_inv_cnt"}, 32'(inv_cnt), 32'd0);
        check({tag, "_s_ready"}, 32'(bif.s_ready), 32'd1);
    endtask

    initial begin
        int low;
        bif.s_valid = 1'b0;
        bif.s_data  = '0;
        bif.m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset");

        // AC after reset: reference is FF / dbi 0
        @(posedge clk);
        #2 mode = 1'b1;
        send(8'h00);
        check("ac_b0_data", 32'(bif.m_data), 32'hFF);
        check("ac_b0_dbi", 32'(bif.m_dbi), 32'd1);
        send(8'h0F);
        check("ac_b1_data", 32'(bif.m_data), 32'hF0);
        check("ac_b1_dbi", 32'(bif.m_dbi), 32'd1);
        repeat (6) send(8'($urandom));

        // DC thresholds
        mode = 1'b0;
        send(8'h0F);
        check("dc_0f_data", 32'(bif.m_data), 32'h0F);
        check("dc_0f_dbi", 32'(bif.m_dbi), 32'd0);
        send(8'h07);
        check("dc_07_data", 32'(bif.m_data), 32'hF8);
        check("dc_07_dbi", 32'(bif.m_dbi), 32'd1);
        send(8'hFF);
        check("dc_ff_data", 32'(bif.m_data), 32'hFF);
        check("dc_ff_dbi", 32'(bif.m_dbi), 32'd0);
        repeat (5) send(8'($urandom));

        // Framing: back-to-back burst, then the two-cycle gap
        mode = 1'($urandom);
        repeat (BL) send(8'($urandom));
        bif.s_valid = 1'b1;
        bif.s_data  = 8'($urandom);
        low = 0;
        @(negedge clk);
        while (!bif.s_ready && low < 10) begin
            low++;
            if (low == 2) check("park_m_valid", 32'(bif.m_valid), 32'd0);
            @(negedge clk);
        end
        check("ready_gap", 32'(low), 32'd2);
        check("parked_data", 32'(bif.m_data), 32'hFF);
        check("parked_dbi", 32'(bif.m_dbi), 32'd0);
        check("parked_valid", 32'(bif.m_valid), 32'd0);
        @(posedge clk);
        #2 bif.s_valid = 1'b0;
        repeat (BL - 1) send(8'($urandom));

        // Backpressure mid-burst
        mode = 1'b1;
        repeat (3) send(8'($urandom));
        bif.m_ready = 1'b0;
        bif.s_valid = 1'b1;
        bif.s_data  = 8'($urandom);
        repeat (3) begin
            @(negedge clk);
            check("bp_s_ready", 32'(bif.s_ready), 32'd0);
            check("bp_m_valid", 32'(bif.m_valid), 32'd1);
        end
        @(posedge clk);
        #2 bif.m_ready = 1'b1;
        send(bif.s_data);
        repeat (BL - 4) send(8'($urandom));

        // Reset mid-burst
        repeat (3) send(8'($urandom));
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk);
        #2 rst_n = 1'b1;
        mode = 1'b1;
        send(8'hFF);
        check("post_rst_data", 32'(bif.m_data), 32'hFF);
        check("post_rst_dbi", 32'(bif.m_dbi), 32'd0);
        repeat (BL - 1) send(8'($urandom));

        // Statistics: five inverted beats, then clear racing an inversion
        repeat (4) @(posedge clk);
        #2 stat_clr = 1'b1;
        @(posedge clk);
        #2 stat_clr = 1'b0;
        mode = 1'b0;
        send(8'h00); send(8'h00); send(8'hFF); send(8'h00);
        send(8'hFF); send(8'h00); send(8'h00); send(8'hFF);
        @(negedge clk);
        check("stat_five", 32'(inv_cnt), 32'd5);
        check("stat_sat_w2", 32'(inv_cnt2), 32'd3);
        repeat (4) @(posedge clk);
        #2 stat_clr = 1'b1;
        send(8'h00);
        stat_clr = 1'b0;
        @(negedge clk);
        check("stat_clr_wins", 32'(inv_cnt), 32'd0);
        repeat (BL - 1) send(8'($urandom));

        // Random traffic with backpressure and mid-burst mode flips
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #2;
            bif.m_ready = ($urandom_range(0, 3) != 0);
            bif.s_valid = 1'($urandom);
            bif.s_data  = 8'($urandom);
            mode        = 1'($urandom);
            stat_clr    = ($urandom_range(0, 63) == 0);
        end
        @(posedge clk);
        #2;
        bif.s_valid = 1'b0;
        bif.m_ready = 1'b1;
        stat_clr    = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("queue_empty", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dbi_burst_encoder.md
# dbi_burst_encoder

Sequential Data Bus Inversion encoder that sits between the write-data source and the pad-side output register of a DBI link. It accepts data beats over a valid/ready handshake and decides per beat whether to drive true or inverted data plus the DBI line. The decision uses the 9-line (8 data + DBI) minimum-transition rule (AC mode) or the minimum-zeros rule (DC mode). It frames traffic into fixed-length bursts and parks the bus between bursts, counting inverted beats for link statistics.

## Interface

- DATA_W, 8, data lanes per beat; even, at least 2.
- BURST_LEN, 8, beats per burst; at least 1.
- CNT_W, 16, width of the inverted-beat statistics counter.

- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  0 = DBI-DC, 1 = DBI-AC; sampled only when a burst starts.
- s_valid  input  1  source beat valid.
- s_data  input  DATA_W  source beat (true polarity).
- s_ready  output  1  encoder accepts a beat this cycle.
- m_valid  output  1  encoded beat valid.
- m_data  output  DATA_W  driven bus data.
- m_dbi  output  1  driven DBI line; 1 means m_data is inverted.
- m_last  output  1  marks the final beat of a burst.
- m_ready  input  1  sink takes the beat.
- stat_clr  input  1  synchronous clear of inv_cnt.
- inv_cnt  output  CNT_W  saturating count of beats sent inverted.

## Operation

- States: IDLE, BURST, DRAIN, PARK. Beat counter beat_cnt counts 0 to BURST_LEN-1.
- Accept occurs on s_valid && s_ready. Transfer occurs on m_valid && m_ready.
- s_ready = (state is IDLE or BURST) && (!m_valid || m_ready). The encoder has a single output register with no skid buffer.
- Reference values ref_d / ref_dbi are the current m_data / m_dbi registers (the last driven bus state), whether or not m_valid is set.
- **AC decision:**
  - t_true = popcount(d ^ ref_d) + (ref_dbi != 0).
  - t_inv = popcount(~d ^ ref_d) + (ref_dbi != 1).
  - Invert iff t_inv < t_true. The sum is always DATA_W+1, which is odd, so no tie exists.
- **DC decision:** invert iff the number of zero bits in d is greater than DATA_W/2. Exactly DATA_W/2 zeros means no inversion.
- On accept:
  - m_data <= invert ? ~d : d.
  - m_dbi <= invert.
  - m_valid <= 1.
  - m_last <= (beat_cnt == BURST_LEN-1).
  - inv_cnt increments if invert.
- IDLE: the first accept latches the burst mode from `mode`, sets beat_cnt to 1 (or goes straight to DRAIN if BURST_LEN==1), and moves to BURST.
- BURST: each accept increments beat_cnt. The accept of beat BURST_LEN-1 moves to DRAIN and clears beat_cnt.
- DRAIN: s_ready is 0. Waits for the transfer with m_last=1, then goes to PARK.
- PARK lasts exactly one cycle:
  - m_valid = 0.
  - m_data <= all ones, m_dbi <= 0. The bus parks high and the AC reference is re-anchored.
  - Next state is IDLE.
- A transfer without a same-cycle accept clears m_valid. m_data and m_dbi hold their values as the reference.
- Simultaneous transfer and accept is allowed in IDLE and BURST and gives one beat per cycle.
- inv_cnt saturates at all ones. If stat_clr is high in the same cycle as an inverted accept, the result is 0 (clear wins).
- A mode change mid-burst is ignored until the next IDLE accept.

## Timing

- Reset values:
  - state = IDLE, beat_cnt = 0.
  - m_valid = 0, m_last = 0.
  - m_data = all ones, m_dbi = 0.
  - inv_cnt = 0.
  - s_ready = 1 immediately after reset deassertion.
- Latency is 1 cycle from accept to m_valid.
- With m_ready held high, the burst takes BURST_LEN cycles of accepts. Then DRAIN accepts nothing and PARK adds 1 cycle, giving 2 idle source cycles between bursts.
- Sink backpressure holds m_data, m_dbi and m_last stable while m_valid && !m_ready.
- Reset asserted mid-burst immediately returns all outputs to their reset values. The partial burst is discarded and no m_last is produced.

## Test plan

- **AC inversion after reset:** mode=1, beats 0x00, 0x0F with m_ready=1.
  - Beat 0x00 → m_data=0xFF, m_dbi=1.
  - Beat 0x0F: t_true=5, t_inv=4 → m_data=0xF0, m_dbi=1.
- **DC thresholds:** mode=0.
  - 0x0F → 0x0F, dbi=0 (4 zeros, no invert).
  - 0x07 → 0xF8, dbi=1.
  - 0xFF → 0xFF, dbi=0.
- **Framing, BURST_LEN=8:** 8 back-to-back beats with m_ready=1.
  - m_last is high on beat 8 only.
  - s_ready is low for exactly 2 cycles after the 8th accept.
  - m_data=0xFF, m_dbi=0 during PARK.
- **Backpressure:** m_ready=0 for 3 cycles mid-burst.
  - m_valid, m_data and m_dbi hold; s_ready=0.
  - After release, the next beat is encoded against the held beat.
- **Reset mid-burst:** rst_n low after beat 3.
  - All outputs immediately return to reset values.
  - The next burst starts at beat_cnt 0 with ref 0xFF/0.
- **Statistics:** 5 inverted beats → inv_cnt=5. stat_clr concurrent with an inverted accept → inv_cnt=0. With CNT_W=2 and 4 inverted beats → inv_cnt=3.
